fp_adder: RTL and testbench

Multi-cycle, parameterizable floating-point adder, IEEE-754-like format {sign, biased exponent, mantissa with hidden 1}.
- A and B are captured on a load pulse. A+B is computed through align / add / normalize stages.
- The packed result is presented with done, overflow and zero flags.
- Used as the add/subtract unit of the customizable FP ALU; subtraction is done by the caller flipping B's sign.

---
 rtl/fp_pkg.sv | 30 +++
 rtl/fp_adder_normalize.sv | 52 +++++
 rtl/fp_adder.sv | 152 +++++++++++++++
 tb/tb_fp_adder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants, FSM state type and operand field helpers for the FP adder.
package fp_pkg;

  localparam int unsigned MANT_SIZE = 23;
  localparam int unsigned EXP_SIZE  = 8;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

  // Helpers work on a 64-bit container; callers cast the return to the field width.
  function automatic logic get_sign(input logic [63:0] x, input int unsigned m,
                                    input int unsigned e);
    return 1'((x >> (m + e)) & 64'd1);
  endfunction

  function automatic logic [63:0] get_exp(input logic [63:0] x, input int unsigned m,
                                          input int unsigned e);
    return (x >> m) & ((64'd1 << e) - 64'd1);
  endfunction

  function automatic logic [63:0] get_mant(input logic [63:0] x, input int unsigned m);
    return x & ((64'd1 << m) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_adder_normalize.sv
// Single-cycle normalizer: leading-zero count plus barrel shift of the raw sum.
module fp_normalize #(
  parameter int unsigned Mantissa_Size = 23,
  parameter int unsigned Exponent_Size = 8
) (
  input  logic [Mantissa_Size+1:0] sum,
  input  logic [Exponent_Size-1:0] exp_in,
  output logic [Mantissa_Size-1:0] mant_c,
  output logic [Exponent_Size-1:0] exp_c,
  output logic                     zero_c,
  output logic                     underflow_c,
  output logic                     overflow_c
);

  localparam int unsigned M   = Mantissa_Size;
  localparam int unsigned E   = Exponent_Size;
  localparam int unsigned LZW = $clog2(M + 2);
  localparam int unsigned EW  = E + LZW + 1;
  localparam logic signed [EW-1:0] EXP_MAX = EW'((2 ** E) - 1);

  logic [LZW-1:0]       lzc;
  logic                 found;
  logic signed [EW-1:0] exp_n;

  // Leading zeros below the carry bit, counted from bit M downwards.
  always_comb begin
    lzc   = '0;
    found = 1'b0;
    for (int i = int'(M); i >= 0; i--) begin
      if (!found && sum[i]) begin
        lzc   = LZW'(int'(M) - i);
        found = 1'b1;
      end
    end
  end

  // Carry-out shifts right with truncation; otherwise shift left by the zero count.
  always_comb begin
    zero_c = (sum == '0);
    if (sum[M+1]) begin
      mant_c = sum[M:1];
      exp_n  = $signed(EW'(exp_in)) + $signed(EW'(1));
    end else begin
      mant_c = M'(sum[M:0] << lzc);
      exp_n  = $signed(EW'(exp_in)) - $signed(EW'(lzc));
    end
    exp_c       = exp_n[E-1:0];
    underflow_c = (exp_n <= $signed(EW'(0)));
    overflow_c  = (exp_n >= EXP_MAX);
  end

endmodule

// File: rtl/fp_adder.sv
// Multi-cycle floating-point adder: capture, align, add, normalize, publish.
module fp_adder
  import fp_pkg::*;
#(
  parameter int unsigned Mantissa_Size = MANT_SIZE,
  parameter int unsigned Exponent_Size = EXP_SIZE
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 enable,
  input  logic                                 load,
  input  logic [Mantissa_Size+Exponent_Size:0] A,
  input  logic [Mantissa_Size+Exponent_Size:0] B,
  output logic [Mantissa_Size+Exponent_Size:0] result,
  output logic                                 done,
  output logic                                 overflow,
  output logic                                 zero_flag
);

  localparam int unsigned M  = Mantissa_Size;
  localparam int unsigned E  = Exponent_Size;
  localparam int unsigned N  = M + E;
  localparam int unsigned SW = M + 1;
  localparam int unsigned XW = M + 2;

  state_t         state;
  logic [N:0]     op_a, op_b;
  logic [SW-1:0]  mag_a, mag_b;
  logic [E-1:0]   exp_w;
  logic [XW-1:0]  sum;
  logic           sum_sign;

  logic           sign_a_c, sign_b_c, sign_c;
  logic [E-1:0]   exp_a_c, exp_b_c, exp_big_c, diff_c;
  logic [SW-1:0]  sig_a_c, sig_b_c, al_a_c, al_b_c;
  logic [XW-1:0]  sum_c;
  logic [M-1:0]   norm_mant_c;
  logic [E-1:0]   norm_exp_c;
  logic           norm_zero_c, norm_under_c, norm_over_c;

  // Operand decode; a zero exponent means a zero operand.
  always_comb begin
    sign_a_c = get_sign(64'(op_a), M, E);
    sign_b_c = get_sign(64'(op_b), M, E);
    exp_a_c  = E'(get_exp(64'(op_a), M, E));
    exp_b_c  = E'(get_exp(64'(op_b), M, E));
    sig_a_c  = (exp_a_c == '0) ? '0 : {1'b1, M'(get_mant(64'(op_a), M))};
    sig_b_c  = (exp_b_c == '0) ? '0 : {1'b1, M'(get_mant(64'(op_b), M))};
  end

  // Alignment: shift the smaller-exponent significand right, dropping shifted-out bits.
  always_comb begin
    if (exp_a_c >= exp_b_c) begin
      diff_c    = exp_a_c - exp_b_c;
      exp_big_c = exp_a_c;
      al_a_c    = sig_a_c;
      al_b_c    = (32'(diff_c) > M + 1) ? '0 : (sig_b_c >> diff_c);
    end else begin
      diff_c    = exp_b_c - exp_a_c;
      exp_big_c = exp_b_c;
      al_b_c    = sig_b_c;
      al_a_c    = (32'(diff_c) > M + 1) ? '0 : (sig_a_c >> diff_c);
    end
  end

  // Signed-magnitude add; larger magnitude sets the sign on effective subtract.
  always_comb begin
    if (sign_a_c == sign_b_c) begin
      sum_c  = XW'(mag_a) + XW'(mag_b);
      sign_c = sign_a_c;
    end else if (mag_a >= mag_b) begin
      sum_c  = XW'(mag_a) - XW'(mag_b);
      sign_c = sign_a_c;
    end else begin
      sum_c  = XW'(mag_b) - XW'(mag_a);
      sign_c = sign_b_c;
    end
  end

  fp_normalize #(
    .Mantissa_Size(M),
    .Exponent_Size(E)
  ) u_norm (
    .sum        (sum),
    .exp_in     (exp_w),
    .mant_c     (norm_mant_c),
    .exp_c      (norm_exp_c),
    .zero_c     (norm_zero_c),
    .underflow_c(norm_under_c),
    .overflow_c (norm_over_c)
  );

  // Control FSM and pipeline registers; enable low freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      result    <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      zero_flag <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      mag_a     <= '0;
      mag_b     <= '0;
      exp_w     <= '0;
      sum       <= '0;
      sum_sign  <= 1'b0;
    end else if (enable) begin
      if (load) begin
        op_a      <= A;
        op_b      <= B;
        done      <= 1'b0;
        overflow  <= 1'b0;
        zero_flag <= 1'b0;
        state     <= ALIGN;
      end else begin
        case (state)
          ALIGN: begin
            mag_a <= al_a_c;
            mag_b <= al_b_c;
            exp_w <= exp_big_c;
            state <= ADD;
          end
          ADD: begin
            sum      <= sum_c;
            sum_sign <= sign_c;
            state    <= NORM;
          end
          NORM: begin
            if (norm_zero_c || norm_under_c) begin
              result    <= '0;
              zero_flag <= 1'b1;
            end else if (norm_over_c) begin
              result   <= {sum_sign, {E{1'b1}}, {M{1'b0}}};
              overflow <= 1'b1;
            end else begin
              result <= {sum_sign, norm_exp_c, norm_mant_c};
            end
            state <= DONE;
          end
          DONE: begin
            done <= 1'b1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fp_adder.sv
// Directed self-checking bench for fp_adder with hand-computed expected values.
module tb_fp_adder;

  localparam int unsigned M = 23;
  localparam int unsigned E = 8;
  localparam int unsigned W = M + E + 1;

  logic         clk = 1'b0;
  logic         rst_n, enable, load;
  logic [W-1:0] a, b, result;
  logic         done, overflow, zero_flag;
  int           n_cmp = 0;
  int           n_err = 0;
  int           lat;

  always #5 clk = ~clk;

  fp_adder #(
    .Mantissa_Size(M),
    .Exponent_Size(E)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .load     (load),
    .A        (a),
    .B        (b),
    .result   (result),
    .done     (done),
    .overflow (overflow),
    .zero_flag(zero_flag)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse load for one edge, then count edges until done (bounded).
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, output int l);
    a    = x;
    b    = y;
    load = 1'b1;
    step();
    load = 1'b0;
    l    = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (done) begin
        l = k;
        break;
      end
    end
  endtask

  task automatic check_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp_res, input logic exp_ovf, input logic exp_zero);
    int l;
    run_op(x, y, l);
    chk({tag, "_latency"}, W'(l), W'(4));
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_overflow"}, W'(overflow), W'(exp_ovf));
    chk({tag, "_zero"}, W'(zero_flag), W'(exp_zero));
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    load   = 1'b0;
    a      = '0;
    b      = '0;
    repeat (2) step();
    chk("reset_result", result, '0);
    chk("reset_done", W'(done), W'(0));
    chk("reset_overflow", W'(overflow), W'(0));
    chk("reset_zero", W'(zero_flag), W'(0));
    rst_n = 1'b1;
    step();

    check_op("same_exp_carry", 32'b0_01111100_11111100011101101110110,
             32'b0_01111100_11111100011101101111000,
             32'b0_01111101_11111100011101101110111, 1'b0, 1'b0);
    repeat (3) step();
    chk("done_held", W'(done), W'(1));
    chk("result_held", result, 32'b0_01111101_11111100011101101110111);

    check_op("overflow", 32'b0_11111111_11111111111111111111111,
             32'b0_11111111_00000000000000000000001,
             32'b0_11111111_00000000000000000000000, 1'b1, 1'b0);
    check_op("exp_diff_1", 32'b0_11111110_00000000000000000000000,
             32'b0_11111101_00000000000000000000010,
             32'b0_11111110_10000000000000000000001, 1'b0, 1'b0);
    check_op("cancel", 32'b0_11111110_00000000000000000000111,
             32'b1_11111110_00000000000000000000111, '0, 1'b0, 1'b1);
    check_op("sub_trunc", 32'b0_11111101_00000000000000000001111,
             32'b1_11111110_00000000000000000000111,
             32'b1_11111101_00000000000000000000000, 1'b0, 1'b0);
    check_op("underflow", 32'b0_00000001_00000000000000000000001,
             32'b1_00000001_00000000000000000000000, '0, 1'b0, 1'b1);
    check_op("zero_operand", '0, 32'b1_10000001_01000000000000000000000,
             32'b1_10000001_01000000000000000000000, 1'b0, 1'b0);
    check_op("huge_diff", 32'b0_11001000_00000000000000000000000,
             32'b0_01100100_00000000000000000000101,
             32'b0_11001000_00000000000000000000000, 1'b0, 1'b0);
    check_op("neg_add", 32'b1_01111111_00000000000000000000000,
             32'b1_01111111_00000000000000000000000,
             32'b1_10000000_00000000000000000000000, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an operation.
    a    = 32'b0_11111110_00000000000000000000000;
    b    = 32'b0_11111101_00000000000000000000010;
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    chk("pre_reset_result", result, 32'b1_10000000_00000000000000000000000);
    rst_n = 1'b0;
    #1;
    chk("midop_reset_result", result, '0);
    chk("midop_reset_done", W'(done), W'(0));
    chk("midop_reset_flags", W'({overflow, zero_flag}), W'(0));
    repeat (5) step();
    chk("reset_hold_done", W'(done), W'(0));
    rst_n = 1'b1;
    step();

    // Enable held low for three edges after the load edge stretches latency by three.
    a    = 32'b0_01111100_11111100011101101110110;
    b    = 32'b0_01111100_11111100011101101111000;
    load = 1'b1;
    step();
    load = 1'b0;
    lat  = -1;
    for (int k = 1; k <= 20; k++) begin
      enable = (k <= 3) ? 1'b0 : 1'b1;
      step();
      if (done) begin
        lat = k;
        break;
      end
    end
    enable = 1'b1;
    chk("enable_stall_latency", W'(lat), W'(7));
    chk("enable_stall_result", result, 32'b0_01111101_11111100011101101110111);

    // Load while disabled is ignored.
    enable = 1'b0;
    load   = 1'b1;
    a      = 32'b0_11111110_00000000000000000000111;
    b      = 32'b1_11111110_00000000000000000000111;
    repeat (2) step();
    load   = 1'b0;
    enable = 1'b1;
    repeat (5) step();
    chk("disabled_load_done", W'(done), W'(1));
    chk("disabled_load_result", result, 32'b0_01111101_11111100011101101110111);
    chk("disabled_load_zero", W'(zero_flag), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
